uart_fifo_core: RTL and testbench
=================================

Name: uart_fifo_core

Overview:
- Parametrised UART transceiver; successor to the fixed 8N1 UART in the system top.
- Adds configurable data width, parity and stop bits, TX and RX FIFOs, and sticky error flags.
- Sits between the CPU bus glue and the uart_rxd/uart_txd pins. Baud timing is derived from clk_freq/uart_baud_rate.

Parameters:
- clk_freq, 100000000: system clock in Hz.
- uart_baud_rate, 115200: line rate. divisor = clk_freq/uart_baud_rate, truncated; must be ≥ 4.
- data_bits, 8: bits per frame, 5..8.
- parity, 0: 0 = none, 1 = odd, 2 = even.
- stop_bits, 1: 1 or 2.
- fifo_depth, 16: entries per FIFO; power of 2, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  data_bits  word to transmit.
- tx_valid  in  1  push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  data_bits  head of RX FIFO (first-word fall-through).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop request.
- tx_count  out  log2(fifo_depth)+1  TX FIFO occupancy.
- rx_count  out  log2(fifo_depth)+1  RX FIFO occupancy.
- tx_busy  out  1  TX FSM not IDLE.
- rx_frame_err  out  1  sticky.
- rx_parity_err  out  1  sticky.
- rx_overrun  out  1  sticky.
- err_clr  in  1  clears all three sticky flags.
- uart_rxd  in  1  serial input, asynchronous.
- uart_txd  out  1  serial output, registered.

Behaviour:
- Reset values: uart_txd=1, tx_ready=1, rx_valid=0, rx_data=0, tx_count=0, rx_count=0, tx_busy=0, all error flags 0. Both FIFOs flushed.
- Reset mid-frame: the partial frame is discarded and uart_txd=1 from the next edge.
- FIFOs:
  - Push on valid&ready; pop on rx_ready&rx_valid.
  - Pop while empty is ignored.
  - RX FIFO full with push and pop in the same cycle: push accepted, no overrun.
  - Pointers wrap modulo fifo_depth.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE with TX FIFO non-empty: pop into shift register, go to START.
  - Each bit period is exactly divisor cycles.
  - START drives 0.
  - DATA sends data_bits bits, LSB first.
  - PARITY (only if parity≠0): even = XOR of data bits; odd = inverted XOR.
  - STOP drives 1 for stop_bits×divisor cycles.
  - At the end of STOP: if FIFO non-empty, pop and enter START directly (no idle gap); else IDLE.
  - Latency: word accepted at edge N into an empty idle TX path gives uart_txd low after edge N+2.
- RX path:
  - uart_rxd passes through a 2-FF synchroniser, both FFs reset to 1.
  - States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: synced line low starts START.
  - START: wait divisor/2 cycles, then sample. High = false start, return to IDLE, no flag.
  - DATA and PARITY: sample every divisor cycles after that point.
  - STOP: only the first stop bit is sampled. After the mid-stop sample the FSM returns to IDLE immediately (resync margin).
  - Stop sample low: set rx_frame_err, discard the word, enter BREAK. BREAK waits for synced line = 1, then IDLE.
  - Parity mismatch: set rx_parity_err, discard the word.
  - Good word while FIFO full and no same-cycle pop: word dropped, rx_overrun set.
  - Good word is pushed in the cycle after the stop sample. rx_valid rises the following cycle.
- Error flags: sticky. err_clr clears them. A new error in the same cycle as err_clr wins (flag set).
- Width: rx_data upper bits beyond data_bits do not exist. data_bits<8 frames carry only data_bits bits.

Test Plan:
All tests use clk_freq=1000000 and uart_baud_rate=100000, giving divisor=10. uart_txd is looped to uart_rxd unless stated.
1. 8N1, push 0xA5 into idle core -> uart_txd low 10 cycles, then 1,0,1,0,0,1,0,1 (10 cycles each), then high 10 cycles. rx_data=0xA5, rx_valid=1, no error flags.
2. parity=2, push 0x07 -> parity bit 1, frame 110 cycles, rx 0x07. Bench then drives 0x07 with parity bit 0 -> rx_parity_err=1, rx_count=0. err_clr -> flag 0.
3. 8N1, tx_valid held with 20 words, one per cycle -> exactly 17 accepted, tx_ready=0, tx_count=16. All 17 frames appear back-to-back with no idle gap between stop and start bits.
4. 8N1, loop 17 frames 0x01..0x11, rx_ready=0 -> rx_count=16, rx_overrun=1, rx_data=0x01. Popping 16 times yields 0x01..0x10.
5. Bench-driven rxd:
   - 3-cycle low glitch -> no word, no flag.
   - Frame 0x3C with stop bit 0, line held low 40 cycles -> rx_frame_err=1, no push. The next valid frame 0x55 is received correctly.
6. rst asserted mid DATA of a TX frame -> uart_txd=1 next cycle, tx_count=0, rx_count=0, tx_busy=0, flags 0. No spurious RX word.

Source files
------------

// File: rtl/uart_fifo_core.sv
// Parametrised UART transceiver with TX/RX FIFOs, configurable framing and sticky RX error flags.
module uart_fifo_core #(
  parameter int unsigned clk_freq       = 100000000,
  parameter int unsigned uart_baud_rate = 115200,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity         = 0,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned fifo_depth     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [data_bits-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [data_bits-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(fifo_depth):0] tx_count,
  output logic [$clog2(fifo_depth):0] rx_count,
  output logic                        tx_busy,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        rx_overrun,
  input  logic                        err_clr,
  input  logic                        uart_rxd,
  output logic                        uart_txd
);
  localparam int unsigned divisor = clk_freq / uart_baud_rate;
  localparam int unsigned aw = $clog2(fifo_depth);
  localparam int unsigned cw = aw + 1;
  localparam int unsigned bw = $clog2(divisor * stop_bits + 1);
  localparam int unsigned iw = $clog2(data_bits);
  localparam logic [bw-1:0] bit_last  = bw'(divisor - 1);
  localparam logic [bw-1:0] half_last = bw'(divisor / 2 - 1);
  localparam logic [bw-1:0] stop_last = bw'(divisor * stop_bits - 1);
  localparam logic [iw-1:0] idx_last  = iw'(data_bits - 1);
  localparam logic par_odd = 1'(parity == 1);

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_start  = 3'd1;
  localparam logic [2:0] st_data   = 3'd2;
  localparam logic [2:0] st_parity = 3'd3;
  localparam logic [2:0] st_stop   = 3'd4;
  localparam logic [2:0] st_break  = 3'd5;

  // TX FIFO
  logic [data_bits-1:0] tx_mem [fifo_depth];
  logic [aw-1:0]        tx_wr, tx_rd;
  logic                 tx_push, tx_pop;

  assign tx_ready = (tx_count != cw'(fifo_depth));
  assign tx_push  = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + aw'(1);
      if (tx_pop)  tx_rd <= tx_rd + aw'(1);
      tx_count <= tx_count + cw'(tx_push) - cw'(tx_pop);
    end
  end

  // TX FSM; uart_txd is registered from the current state so it trails the state by one cycle
  logic [2:0]           tx_state, tx_state_n;
  logic [bw-1:0]        tx_cnt, tx_cnt_n;
  logic [iw-1:0]        tx_idx, tx_idx_n;
  logic [data_bits-1:0] tx_shift, tx_shift_n;
  logic                 txd_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= st_idle;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      uart_txd <= txd_c;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + bw'(1);
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    txd_c      = 1'b1;
    case (tx_state)
      st_idle: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_mem[tx_rd];
          tx_state_n = st_start;
        end
      end
      st_start: begin
        txd_c = 1'b0;
        if (tx_cnt == bit_last) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = st_data;
        end
      end
      st_data: begin
        txd_c = tx_shift[tx_idx];
        if (tx_cnt == bit_last) begin
          tx_cnt_n = '0;
          tx_idx_n = tx_idx + iw'(1);
          if (tx_idx == idx_last) tx_state_n = (parity != 0) ? st_parity : st_stop;
        end
      end
      st_parity: begin
        txd_c = ^tx_shift ^ par_odd;
        if (tx_cnt == bit_last) begin
          tx_cnt_n   = '0;
          tx_state_n = st_stop;
        end
      end
      st_stop: begin
        if (tx_cnt == stop_last) begin
          tx_cnt_n = '0;
          if (tx_count != '0) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_mem[tx_rd];
            tx_state_n = st_start;
          end else begin
            tx_state_n = st_idle;
          end
        end
      end
      default: tx_state_n = st_idle;
    endcase
  end

  assign tx_busy = (tx_state != st_idle);

  // RX FIFO; head is forced to zero while empty so reset leaves rx_data at 0
  logic [data_bits-1:0] rx_mem [fifo_depth];
  logic [aw-1:0]        rx_wr, rx_rd;
  logic                 rx_push, rx_pop, rx_full, rx_good;

  assign rx_full  = (rx_count == cw'(fifo_depth));
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_ready & rx_valid;
  assign rx_push  = rx_good & (~rx_full | rx_pop);
  assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;

  // RX FSM with 2-FF synchroniser; only the first stop bit is sampled
  logic [1:0]           rx_sync;
  logic [2:0]           rx_state, rx_state_n;
  logic [bw-1:0]        rx_cnt, rx_cnt_n;
  logic [iw-1:0]        rx_idx, rx_idx_n;
  logic [data_bits-1:0] rx_shift, rx_shift_n;
  logic                 rx_par_bad, rx_par_bad_n, rx_good_n, frame_set, par_set, rxs;

  assign rxs = rx_sync[1];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync       <= 2'b11;
      rx_state      <= st_idle;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bad    <= 1'b0;
      rx_good       <= 1'b0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      rx_count      <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_sync       <= {rx_sync[0], uart_rxd};
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_idx        <= rx_idx_n;
      rx_shift      <= rx_shift_n;
      rx_par_bad    <= rx_par_bad_n;
      rx_good       <= rx_good_n;
      if (rx_push) rx_wr <= rx_wr + aw'(1);
      if (rx_pop)  rx_rd <= rx_rd + aw'(1);
      rx_count      <= rx_count + cw'(rx_push) - cw'(rx_pop);
      rx_frame_err  <= (rx_frame_err & ~err_clr) | frame_set;
      rx_parity_err <= (rx_parity_err & ~err_clr) | par_set;
      rx_overrun    <= (rx_overrun & ~err_clr) | (rx_good & rx_full & ~rx_pop);
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt + bw'(1);
    rx_idx_n     = rx_idx;
    rx_shift_n   = rx_shift;
    rx_par_bad_n = rx_par_bad;
    rx_good_n    = 1'b0;
    frame_set    = 1'b0;
    par_set      = 1'b0;
    case (rx_state)
      st_idle: begin
        rx_cnt_n = '0;
        if (!rxs) rx_state_n = st_start;
      end
      st_start: begin
        if (rx_cnt == half_last) begin
          rx_cnt_n     = '0;
          rx_idx_n     = '0;
          rx_par_bad_n = 1'b0;
          rx_state_n   = rxs ? st_idle : st_data;
        end
      end
      st_data: begin
        if (rx_cnt == bit_last) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxs, rx_shift[data_bits-1:1]};
          rx_idx_n   = rx_idx + iw'(1);
          if (rx_idx == idx_last) rx_state_n = (parity != 0) ? st_parity : st_stop;
        end
      end
      st_parity: begin
        if (rx_cnt == bit_last) begin
          rx_cnt_n   = '0;
          rx_state_n = st_stop;
          if (rxs != (^rx_shift ^ par_odd)) begin
            rx_par_bad_n = 1'b1;
            par_set      = 1'b1;
          end
        end
      end
      st_stop: begin
        if (rx_cnt == bit_last) begin
          rx_cnt_n = '0;
          if (!rxs) begin
            frame_set  = 1'b1;
            rx_state_n = st_break;
          end else begin
            rx_good_n  = ~rx_par_bad;
            rx_state_n = st_idle;
          end
        end
      end
      st_break: begin
        rx_cnt_n = '0;
        if (rxs) rx_state_n = st_idle;
      end
      default: rx_state_n = st_idle;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed self-checking bench: one 8N1 core and one even-parity core, each with selectable loopback.
module tb_uart_fifo_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_tx_data, a_rx_data, b_tx_data, b_rx_data;
  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready, a_tx_busy;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_tx_busy;
  logic [4:0] a_tx_count, a_rx_count, b_tx_count, b_rx_count;
  logic       a_fe, a_pe, a_ov, a_err_clr, a_rxd, a_txd, a_loop, a_drv;
  logic       b_fe, b_pe, b_ov, b_err_clr, b_rxd, b_txd, b_loop, b_drv;

  assign a_rxd = a_loop ? a_txd : a_drv;
  assign b_rxd = b_loop ? b_txd : b_drv;

  uart_fifo_core #(.clk_freq(1000000), .uart_baud_rate(100000), .data_bits(8),
                   .parity(0), .stop_bits(1), .fifo_depth(16)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .tx_count(a_tx_count), .rx_count(a_rx_count), .tx_busy(a_tx_busy),
    .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ov), .err_clr(a_err_clr),
    .uart_rxd(a_rxd), .uart_txd(a_txd));

  uart_fifo_core #(.clk_freq(1000000), .uart_baud_rate(100000), .data_bits(8),
                   .parity(2), .stop_bits(1), .fifo_depth(16)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .tx_count(b_tx_count), .rx_count(b_rx_count), .tx_busy(b_tx_busy),
    .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ov), .err_clr(b_err_clr),
    .uart_rxd(b_rxd), .uart_txd(b_txd));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected line level for bit period b of a frame (start, 8 data LSB first, optional parity, stop)
  function automatic logic fbit(input logic [7:0] d, input bit par_en, input logic p, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && par_en) return p;
    return 1'b1;
  endfunction

  task automatic set_line(input bit which, input logic v);
    if (which) b_drv = v;
    else a_drv = v;
  endtask

  task automatic drive(input bit which, input logic [7:0] d, input bit par_en, input logic p,
                       input logic stop, input int stop_len);
    set_line(which, 1'b0);
    tick(10);
    for (int j = 0; j < 8; j++) begin
      set_line(which, d[j]);
      tick(10);
    end
    if (par_en) begin
      set_line(which, p);
      tick(10);
    end
    set_line(which, stop);
    tick(stop_len);
    set_line(which, 1'b1);
  endtask

  logic [7:0] rxq [$];
  int         acc, bad, idx;
  logic       e;

  initial begin
    rst = 1'b1;
    a_tx_data = '0; a_tx_valid = 0; a_rx_ready = 0; a_err_clr = 0; a_loop = 1; a_drv = 1;
    b_tx_data = '0; b_tx_valid = 0; b_rx_ready = 0; b_err_clr = 0; b_loop = 1; b_drv = 1;
    tick(3);
    chk("rst_txd", 32'(a_txd), 1);
    chk("rst_tx_ready", 32'(a_tx_ready), 1);
    chk("rst_rx_valid", 32'(a_rx_valid), 0);
    chk("rst_rx_data", 32'(a_rx_data), 0);
    chk("rst_tx_count", 32'(a_tx_count), 0);
    chk("rst_rx_count", 32'(a_rx_count), 0);
    chk("rst_tx_busy", 32'(a_tx_busy), 0);
    chk("rst_flags", 32'({a_fe, a_pe, a_ov}), 0);
    rst = 1'b0;
    tick(2);

    // Test 1: 8N1 0xA5, exact line waveform and loopback receive
    a_tx_data = 8'hA5; a_tx_valid = 1;
    tick(1);
    a_tx_valid = 0;
    chk("t1_txd_n0", 32'(a_txd), 1);
    tick(1);
    chk("t1_txd_n1", 32'(a_txd), 1);
    tick(1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_txd !== fbit(8'hA5, 0, 1'b0, i / 10)) bad++;
      tick(1);
    end
    chk("t1_line_errs", 32'(bad), 0);
    tick(5);
    chk("t1_rx_valid", 32'(a_rx_valid), 1);
    chk("t1_rx_data", 32'(a_rx_data), 'hA5);
    chk("t1_rx_count", 32'(a_rx_count), 1);
    chk("t1_flags", 32'({a_fe, a_pe, a_ov}), 0);
    a_rx_ready = 1; tick(1); a_rx_ready = 0;
    chk("t1_rx_pop", 32'(a_rx_count), 0);

    // Test 2: even parity 0x07 -> parity bit 1, 110-cycle frame
    b_tx_data = 8'h07; b_tx_valid = 1;
    tick(1);
    b_tx_valid = 0;
    tick(2);
    bad = 0;
    for (int i = 0; i < 110; i++) begin
      if (b_txd !== fbit(8'h07, 1, 1'b1, i / 10)) bad++;
      if (i == 95) chk("t2_parity_bit", 32'(b_txd), 1);
      tick(1);
    end
    chk("t2_line_errs", 32'(bad), 0);
    chk("t2_txd_idle", 32'(b_txd), 1);
    tick(5);
    chk("t2_rx_data", 32'(b_rx_data), 'h07);
    chk("t2_rx_valid", 32'(b_rx_valid), 1);
    chk("t2_pe_clean", 32'({b_fe, b_pe, b_ov}), 0);
    b_rx_ready = 1; tick(1); b_rx_ready = 0;
    b_loop = 0;
    drive(1'b1, 8'h07, 1, 1'b0, 1'b1, 10);
    tick(5);
    chk("t2_pe_set", 32'(b_pe), 1);
    chk("t2_pe_count", 32'(b_rx_count), 0);
    b_err_clr = 1; tick(1); b_err_clr = 0;
    chk("t2_pe_clr", 32'(b_pe), 0);
    chk("t2_b_idle", 32'({b_tx_ready, b_tx_busy, b_fe, b_ov, b_tx_count}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 5'd0}));

    // Test 3: 20 words offered back-to-back; 17 accepted, continuous frames, all received
    a_rx_ready = 1; acc = 0; bad = 0; rxq.delete();
    for (int k = 0; k < 1740; k++) begin
      idx = k - 3;
      e = (idx < 0 || idx >= 1700) ? 1'b1 : fbit(8'(8'h30 + idx / 100), 0, 1'b0, (idx % 100) / 10);
      if (a_txd !== e) bad++;
      if (a_rx_valid) rxq.push_back(a_rx_data);
      if (k == 20) begin
        chk("t3_tx_ready_full", 32'(a_tx_ready), 0);
        chk("t3_tx_count_full", 32'(a_tx_count), 16);
      end
      if (k < 20) begin
        a_tx_valid = 1; a_tx_data = 8'(8'h30 + k);
        if (a_tx_ready) acc++;
      end else begin
        a_tx_valid = 0;
      end
      tick(1);
    end
    a_rx_ready = 0;
    chk("t3_accepted", 32'(acc), 17);
    chk("t3_stream_errs", 32'(bad), 0);
    chk("t3_rx_words", 32'(rxq.size()), 17);
    for (int j = 0; j < 17; j++)
      if (j < rxq.size()) chk("t3_rx_word", 32'(rxq[j]), 32'(8'h30 + j));
    chk("t3_tx_busy_end", 32'(a_tx_busy), 0);
    chk("t3_flags", 32'({a_fe, a_pe, a_ov}), 0);

    // Test 4: 17 frames into a non-draining RX FIFO -> overrun, head 0x01
    for (int k = 0; k < 1740; k++) begin
      if (k < 17) begin a_tx_valid = 1; a_tx_data = 8'(k + 1); end
      else a_tx_valid = 0;
      tick(1);
    end
    chk("t4_rx_count", 32'(a_rx_count), 16);
    chk("t4_overrun", 32'(a_ov), 1);
    chk("t4_head", 32'(a_rx_data), 'h01);
    chk("t4_other_flags", 32'({a_fe, a_pe}), 0);
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      if (a_rx_data !== 8'(j + 1) || a_rx_valid !== 1'b1) bad++;
      a_rx_ready = 1; tick(1); a_rx_ready = 0;
    end
    chk("t4_pop_errs", 32'(bad), 0);
    chk("t4_rx_empty", 32'({a_rx_valid, a_rx_count}), 0);
    a_err_clr = 1; tick(1); a_err_clr = 0;
    chk("t4_ov_clr", 32'(a_ov), 0);

    // Test 5: glitch, framing error with break, then clean frame
    a_loop = 0;
    a_drv = 0; tick(3); a_drv = 1;
    tick(30);
    chk("t5_glitch_count", 32'(a_rx_count), 0);
    chk("t5_glitch_flags", 32'({a_fe, a_pe, a_ov}), 0);
    drive(1'b0, 8'h3C, 0, 1'b0, 1'b0, 40);
    tick(20);
    chk("t5_fe_set", 32'(a_fe), 1);
    chk("t5_fe_no_push", 32'(a_rx_count), 0);
    drive(1'b0, 8'h55, 0, 1'b0, 1'b1, 10);
    tick(10);
    chk("t5_rx_count", 32'(a_rx_count), 1);
    chk("t5_rx_data", 32'(a_rx_data), 'h55);
    a_rx_ready = 1; a_err_clr = 1; tick(1); a_rx_ready = 0; a_err_clr = 0;
    chk("t5_fe_clr", 32'(a_fe), 0);

    // Test 6: reset in the middle of a TX data bit
    a_loop = 1;
    a_tx_data = 8'h00; a_tx_valid = 1;
    tick(2);
    a_tx_valid = 0;
    tick(39);
    chk("t6_pre_txd", 32'(a_txd), 0);
    chk("t6_pre_busy", 32'(a_tx_busy), 1);
    chk("t6_pre_count", 32'(a_tx_count), 1);
    rst = 1; tick(1);
    chk("t6_txd", 32'(a_txd), 1);
    chk("t6_tx_count", 32'(a_tx_count), 0);
    chk("t6_rx_count", 32'(a_rx_count), 0);
    chk("t6_busy", 32'(a_tx_busy), 0);
    chk("t6_flags", 32'({a_fe, a_pe, a_ov}), 0);
    rst = 0;
    tick(200);
    chk("t6_no_spurious", 32'({a_rx_valid, a_rx_count}), 0);
    chk("t6_post_flags", 32'({a_fe, a_pe, a_ov}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
